ram_checker: RTL and testbench

- Downstream self-check stage for the single-port 256x8 RAM subsystem.
- Passively monitors the controller-to-RAM bus (address, write data, write enable) and the RAM read data.
- Verifies that a full write pass followed by a full read-back pass returns the expected pattern.
- Reports done/pass, a saturating error count and the first failing address, for LEDs or a debug tap.

---
 rtl/ram_checker.sv | 134 +++++++++++++
 tb/tb_ram_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_checker.sv
// Passive self-check for a single-port RAM: watches one full write pass and one full
// read-back pass, then reports done/pass, a saturating error count and the first bad address.
module ram_checker #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int OFFSET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wren_in,
  input  logic [DATA_W-1:0] q_in,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_cnt,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [1:0]        phase
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] WR_FINAL = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]  wr_cnt, rd_cnt;
  logic [ADDR_W-1:0] addr_d;
  logic              rd_vld;

  logic       wr_hit, rd_issue;
  logic       wr_err, seq_err, proto_err, data_err;
  logic [1:0] err_inc;
  logic [8:0] err_sum;
  logic [7:0] err_cnt_n;

  function automatic logic [DATA_W-1:0] exp_of(input logic [ADDR_W-1:0] a);
    return DATA_W'(32'(a) + 32'(OFFSET));
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    wr_hit    = 1'b0;
    rd_issue  = 1'b0;
    wr_err    = 1'b0;
    seq_err   = 1'b0;
    proto_err = 1'b0;
    data_err  = 1'b0;

    unique case (state)
      IDLE: begin
        if (wren_in && addr_in == '0) begin
          wr_hit  = 1'b1;
          state_n = WRITE;
        end
      end
      WRITE: wr_hit = wren_in;
      READ: begin
        // Once every read is issued the bus is ignored while the last compare drains.
        if (rd_cnt != CNT_LAST) begin
          if (wren_in) proto_err = 1'b1;
          else         rd_issue  = 1'b1;
        end
        if (rd_vld) data_err = (q_in != exp_of(addr_d));
        if (rd_vld && rd_cnt == CNT_LAST) state_n = DONE;
      end
      DONE: ;
      default: state_n = IDLE;
    endcase

    // The read pass starts on the cycle right after the final write.
    if (wr_hit) begin
      wr_err = ({1'b0, addr_in} != wr_cnt) || (data_in != exp_of(addr_in));
      if (wr_cnt == WR_FINAL) state_n = READ;
    end
    if (rd_issue) seq_err = ({1'b0, addr_in} != rd_cnt);

    err_inc   = 2'(wr_err) + 2'(seq_err) + 2'(proto_err) + 2'(data_err);
    err_sum   = {1'b0, err_cnt} + 9'(err_inc);
    err_cnt_n = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt          <= '0;
      rd_cnt          <= '0;
      addr_d          <= '0;
      rd_vld          <= 1'b0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
    end else begin
      if (wr_hit) wr_cnt <= wr_cnt + CNT_W'(1);
      if (rd_issue) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
        addr_d <= addr_in;
      end
      rd_vld  <= rd_issue;
      err_cnt <= err_cnt_n;
      // A data error belongs to the older read, so its address wins a same-cycle tie.
      if (!first_err_valid && err_inc != 2'd0) begin
        first_err_valid <= 1'b1;
        first_err_addr  <= data_err ? addr_d : addr_in;
      end
      if (state == READ && state_n == DONE) begin
        done <= 1'b1;
        pass <= (err_cnt_n == 8'd0);
      end
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_ram_checker.sv
// Self-checking bench for ram_checker: table of full-run scenarios checked through a
// scoreboard queue, plus hand sequences for latency, DONE hold and mid-read reset.
module tb_ram_checker;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int N    = 256;
  localparam int OFS1 = 240;

  typedef struct {
    string      name;
    int         sel;
    int         wr_bad_addr;
    logic [7:0] wr_bad_data;
    int         rd_bad_addr;
    bit         rd_all_bad;
    bit         stalls;
    bit         skip_proto;
    logic [7:0] exp_err;
    logic       exp_fev;
    logic [7:0] exp_fea;
    logic       exp_pass;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] addr_in [2];
  logic [DW-1:0] data_in [2];
  logic          wren_in [2];
  logic [DW-1:0] q_in    [2];
  logic          done    [2];
  logic          pass    [2];
  logic [7:0]    err_cnt [2];
  logic          fev     [2];
  logic [AW-1:0] fea     [2];
  logic [1:0]    phase   [2];

  ram_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(N), .OFFSET(0)) u_dut0 (
    .clk(clk), .rst(rst), .addr_in(addr_in[0]), .data_in(data_in[0]),
    .wren_in(wren_in[0]), .q_in(q_in[0]), .done(done[0]), .pass(pass[0]),
    .err_cnt(err_cnt[0]), .first_err_valid(fev[0]), .first_err_addr(fea[0]),
    .phase(phase[0])
  );

  ram_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(N), .OFFSET(OFS1)) u_dut1 (
    .clk(clk), .rst(rst), .addr_in(addr_in[1]), .data_in(data_in[1]),
    .wren_in(wren_in[1]), .q_in(q_in[1]), .done(done[1]), .pass(pass[1]),
    .err_cnt(err_cnt[1]), .first_err_valid(fev[1]), .first_err_addr(fea[1]),
    .phase(phase[1])
  );

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t sb[$];
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] expf(input int sel, input int a);
    return 8'(a + ((sel == 1) ? OFS1 : 0));
  endfunction

  function automatic logic [7:0] resp(input vec_t v, input int a);
    if (v.rd_all_bad) return ~expf(v.sel, a);
    if (a == v.rd_bad_addr) return 8'hFF;
    return expf(v.sel, a);
  endfunction

  function automatic vec_t mk(input string name, input int sel, input int wba, input logic [7:0] wbd,
                              input int rba, input bit all_bad, input bit stalls, input bit skp,
                              input logic [7:0] e_err, input logic e_fev, input logic [7:0] e_fea,
                              input logic e_pass);
    vec_t v;
    v.name = name; v.sel = sel; v.wr_bad_addr = wba; v.wr_bad_data = wbd;
    v.rd_bad_addr = rba; v.rd_all_bad = all_bad; v.stalls = stalls; v.skip_proto = skp;
    v.exp_err = e_err; v.exp_fev = e_fev; v.exp_fea = e_fea; v.exp_pass = e_pass;
    return v;
  endfunction

  task automatic idle_bus();
    for (int s = 0; s < 2; s++) begin
      addr_in[s] = '0; data_in[s] = '0; wren_in[s] = 1'b0; q_in[s] = '0;
    end
  endtask

  task automatic check_cleared(input int sel, input string tag);
    check({tag, "_phase"}, 32'(phase[sel]), 0);
    check({tag, "_done"},  32'(done[sel]), 0);
    check({tag, "_pass"},  32'(pass[sel]), 0);
    check({tag, "_err"},   32'(err_cnt[sel]), 0);
    check({tag, "_fev"},   32'(fev[sel]), 0);
    check({tag, "_fea"},   32'(fea[sel]), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_bus();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_pass(input vec_t v);
    for (int a = 0; a < N; a++) begin
      if (v.stalls && (a % 64) == 10) begin
        @(negedge clk);
        check({v.name, "_phase_write"}, 32'(phase[v.sel]), 1);
        wren_in[v.sel] = 1'b0; addr_in[v.sel] = 8'(a + 3); data_in[v.sel] = 8'hA5;
      end
      @(negedge clk);
      wren_in[v.sel] = 1'b1;
      addr_in[v.sel] = 8'(a);
      data_in[v.sel] = (a == v.wr_bad_addr) ? v.wr_bad_data : expf(v.sel, a);
    end
  endtask

  // Issues reads 0..stop_at-1; q_in always carries the response to the previous issue.
  task automatic read_pass(input vec_t v, input int stop_at, output int prev, output bit have);
    have = 1'b0;
    prev = 0;
    for (int k = 0; k < stop_at; k++) begin
      int a;
      if (v.skip_proto && k == 50) begin
        @(negedge clk);
        wren_in[v.sel] = 1'b1; addr_in[v.sel] = 8'(k); data_in[v.sel] = 8'h00;
        q_in[v.sel] = have ? resp(v, prev) : 8'h00;
        have = 1'b0;
      end
      a = (v.skip_proto && k == 5) ? 6 : k;
      @(negedge clk);
      wren_in[v.sel] = 1'b0; addr_in[v.sel] = 8'(a); data_in[v.sel] = 8'h00;
      q_in[v.sel] = have ? resp(v, prev) : 8'h00;
      have = 1'b1;
      prev = a;
    end
  endtask

  task automatic run_vec(input vec_t v, input bit with_reset);
    int   prev;
    bit   have;
    int   lat;
    vec_t e;
    if (with_reset) begin
      do_reset();
      check_cleared(v.sel, {v.name, "_rst"});
    end
    sb.push_back(v);
    write_pass(v);
    read_pass(v, N, prev, have);
    // Compare cycle for the last read: done must still be low here.
    @(negedge clk);
    check({v.name, "_done_early"}, 32'(done[v.sel]), 0);
    wren_in[v.sel] = 1'b0; addr_in[v.sel] = '0;
    q_in[v.sel] = have ? resp(v, prev) : 8'h00;
    @(negedge clk);
    idle_bus();
    lat = 2;
    while (!done[v.sel] && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({v.name, "_latency"}, 32'(lat), 2);
    e = sb.pop_front();
    check({e.name, "_done"}, 32'(done[e.sel]), 1);
    check({e.name, "_phase"}, 32'(phase[e.sel]), 3);
    check({e.name, "_err"}, 32'(err_cnt[e.sel]), 32'(e.exp_err));
    check({e.name, "_fev"}, 32'(fev[e.sel]), 32'(e.exp_fev));
    check({e.name, "_fea"}, 32'(fea[e.sel]), 32'(e.exp_fea));
    check({e.name, "_pass"}, 32'(pass[e.sel]), 32'(e.exp_pass));
    // Bus activity in DONE must not disturb anything.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      wren_in[v.sel] = (c != 1); addr_in[v.sel] = 8'(c); data_in[v.sel] = 8'h55;
      q_in[v.sel] = 8'hC3;
    end
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    check({e.name, "_hold_done"}, 32'(done[e.sel]), 1);
    check({e.name, "_hold_err"}, 32'(err_cnt[e.sel]), 32'(e.exp_err));
    check({e.name, "_hold_pass"}, 32'(pass[e.sel]), 32'(e.exp_pass));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    bit have;
    rst = 1'b1;
    idle_bus();

    //          name        sel wr_bad  wbd    rd_bad all stl skp err    fev  fea    pass
    vecs[0] = mk("clean",    0, -1,     8'h00, -1,    0,  0,  0,  8'd0,  0, 8'h00, 1);
    vecs[1] = mk("rd_corr",  0, -1,     8'h00, 16,    0,  0,  0,  8'd1,  1, 8'h10, 0);
    vecs[2] = mk("wr_wrap",  1, 32,     8'h00, -1,    0,  0,  0,  8'd1,  1, 8'h20, 0);
    vecs[3] = mk("seq_prot", 0, -1,     8'h00, -1,    0,  1,  1,  8'd2,  1, 8'h06, 0);
    vecs[4] = mk("saturate", 0, -1,     8'h00, -1,    1,  0,  0,  8'd255,1, 8'h00, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b1);

    // Reset one cycle into read index 100 with a bad compare in flight.
    do_reset();
    write_pass(vecs[0]);
    read_pass(vecs[0], 100, prev, have);
    @(negedge clk);
    check("midrd_phase_read", 32'(phase[0]), 2);
    rst = 1'b1;
    wren_in[0] = 1'b0; addr_in[0] = 8'd100; q_in[0] = 8'hEE;
    @(negedge clk);
    rst = 1'b0;
    idle_bus();
    check_cleared(0, "midrd");
    run_vec(vecs[0], 1'b0);

    check("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
